// File: rtl/seg7_scan.sv
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
// Presents one digit's code on bin per scan slot and drives the active-low anodes and decimal point.
module seg7_scan #(
   parameter int N_DIGITS = 4,
   parameter int PRESC    = 50000,
   parameter int GUARD    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*N_DIGITS-1:0]   data,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic [N_DIGITS-1:0]     blank,
   input  logic                    load,
   input  logic                    lz,
   input  logic                    en,
   output logic [3:0]              bin,
   output logic [N_DIGITS-1:0]     an_n,
   output logic                    dp_n,
   output logic                    frame
);

   localparam int IW = $clog2(N_DIGITS);
   localparam int PW = $clog2(PRESC);
   localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

   logic [4*N_DIGITS-1:0] shadow_data;
   logic [N_DIGITS-1:0]   shadow_dp;
   logic [N_DIGITS-1:0]   shadow_blank;
   logic [PW-1:0]         presc;
   logic [IW-1:0]         idx;
   logic                  slot_blank;
   logic                  slot_lead;
   logic                  slot_dp;
   logic                  cur_lead;

   // A digit is a leading zero when it and every more significant shadow digit is zero.
   always_comb begin
      cur_lead = 1'b0;
      if (idx != '0) begin
         cur_lead = 1'b1;
         for (int k = 0; k < N_DIGITS; k++) begin
            if (k >= int'(idx) && shadow_data[4*k +: 4] != 4'h0) begin
               cur_lead = 1'b0;
            end
         end
      end
   end

   // The shadow is only sampled at slot start; the slot_* copies keep the digit stable all slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_data  <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
         presc        <= '0;
         idx          <= '0;
         slot_blank   <= 1'b0;
         slot_lead    <= 1'b0;
         slot_dp      <= 1'b0;
         bin          <= 4'h0;
         an_n         <= '1;
         dp_n         <= 1'b1;
         frame        <= 1'b0;
      end else begin
         if (load) begin
            shadow_data  <= data;
            shadow_dp    <= dp_in;
            shadow_blank <= blank;
         end

         if (presc == PW'(PRESC - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end

         frame <= 1'b0;
         if (presc == '0) begin
            bin        <= shadow_data[4*idx +: 4];
            slot_blank <= shadow_blank[idx];
            slot_lead  <= cur_lead;
            slot_dp    <= shadow_dp[idx];
            dp_n       <= ~(shadow_dp[idx] & ~shadow_blank[idx] & ~(lz & cur_lead));
            an_n       <= '1;
            frame      <= (idx == '0);
         end else begin
            dp_n <= ~(slot_dp & ~slot_blank & ~(lz & slot_lead));
            if (presc >= PW'(GUARD) && en && !slot_blank && !(lz && slot_lead)) begin
               an_n <= ~(ONE_HOT0 << idx);
            end else begin
               an_n <= '1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan, compared cycle by cycle against a slot/position model
// derived from a plain cycle count since reset.
module tb_seg7_scan;

   localparam int N     = 4;
   localparam int PRESC = 8;
   localparam int GUARD = 2;
   localparam int NCYC  = 3000;

   logic           clk = 1'b0;
   logic           rst;
   logic [4*N-1:0] data;
   logic [N-1:0]   dp_in;
   logic [N-1:0]   blank;
   logic           load;
   logic           lz;
   logic           en;
   logic [3:0]     bin;
   logic [N-1:0]   an_n;
   logic           dp_n;
   logic           frame;

   int errors = 0;
   int checks = 0;

   int             k;
   logic [4*N-1:0] m_data, snap_data;
   logic [N-1:0]   m_dp, m_blank, snap_dp, snap_blank;
   logic [3:0]     exp_bin;
   logic [N-1:0]   exp_an;
   logic           exp_dp;
   logic           exp_frame;

   seg7_scan #(.N_DIGITS(N), .PRESC(PRESC), .GUARD(GUARD)) dut (
      .clk   (clk),
      .rst   (rst),
      .data  (data),
      .dp_in (dp_in),
      .blank (blank),
      .load  (load),
      .lz    (lz),
      .en    (en),
      .bin   (bin),
      .an_n  (an_n),
      .dp_n  (dp_n),
      .frame (frame)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected, input int cyc);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, observed, expected);
      end
   endtask

   // Roughly half the nibbles are zero so that leading-zero suppression gets exercised.
   function automatic logic [4*N-1:0] randData();
      logic [4*N-1:0] v = '0;
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   // Predicts what the next clock edge produces from the inputs now applied.
   task automatic modelStep();
      int   p, d;
      logic lead, vis;
      if (rst) begin
         exp_bin    = 4'h0;
         exp_an     = '1;
         exp_dp     = 1'b1;
         exp_frame  = 1'b0;
         m_data     = '0;
         m_dp       = '0;
         m_blank    = '0;
         snap_data  = '0;
         snap_dp    = '0;
         snap_blank = '0;
         k          = 0;
         return;
      end
      p = k % PRESC;
      d = (k / PRESC) % N;
      if (p == 0) begin
         snap_data  = m_data;
         snap_dp    = m_dp;
         snap_blank = m_blank;
         exp_bin    = snap_data[4*d +: 4];
      end
      lead      = (d != 0) && ((snap_data >> (4*d)) == 0);
      vis       = en && !snap_blank[d] && !(lz && lead);
      exp_frame = (p == 0) && (d == 0);
      exp_an    = (p != 0 && p >= GUARD && vis) ? ~(N'(1) << d) : '1;
      exp_dp    = !(snap_dp[d] && !snap_blank[d] && !(lz && lead));
      if (load) begin
         m_data  = data;
         m_dp    = dp_in;
         m_blank = blank;
      end
      k++;
   endtask

   // Early cycles run a clean display; later cycles add blanking, LZ toggling, EN drops and resets.
   task automatic applyStimulus(input int cyc);
      rst   = (cyc < 3) || ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 7) == 0) || (cyc == 3);
      data  = (cyc == 3) ? 16'h1234 : randData();
      dp_in = N'($urandom_range(0, 15));
      if (cyc < 400) begin
         blank = '0;
         en    = 1'b1;
         lz    = 1'b0;
      end else begin
         blank = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
         en    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) lz = ~lz;
      end
      modelStep();
   endtask

   initial begin
      rst   = 1'b1;
      load  = 1'b0;
      data  = '0;
      dp_in = '0;
      blank = '0;
      lz    = 1'b0;
      en    = 1'b1;
      k     = 0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         applyStimulus(cyc);
         @(posedge clk);
         #1;
         checkOutput("bin", 32'(bin), 32'(exp_bin), cyc);
         checkOutput("an_n", 32'(an_n), 32'(exp_an), cyc);
         checkOutput("dp_n", 32'(dp_n), 32'(exp_dp), cyc);
         checkOutput("frame", 32'(frame), 32'(exp_frame), cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
